// File: rtl/mem_port_sequencer_pkg.sv
// Shared types and defaults for the memory-port sequencer and its arbiter.
package mem_port_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned WAIT_STATES_DEF = 1;
  localparam int unsigned STARVE_MAX_DEF  = 3;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned STARVE_W        = 8;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision for the shared memory port: DM wins ties until IF has been
// passed over STARVE_MAX times in a row.
module mem_arb_prio
  import mem_port_sequencer_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                i_if_req,
  input  logic                i_dm_req,
  input  logic [STARVE_W-1:0] i_starve,
  output logic                o_grant_if,
  output logic                o_grant_dm
);

  logic w_force_if;

  always_comb begin
    w_force_if = i_if_req && (i_starve == STARVE_W'(STARVE_MAX));
    o_grant_dm = i_dm_req && !w_force_if;
    o_grant_if = i_if_req && !o_grant_dm;
  end

endmodule

// File: rtl/mem_port_sequencer.sv
// Sequences IF fetches and DM loads/stores through one registered-address
// memory port with a fixed wait-state window.
module mem_port_sequencer
  import mem_port_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
  parameter int unsigned STARVE_MAX  = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic [15:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_ready,
  output logic [15:0] dm_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  input  logic [15:0] mem_q,
  output logic        stall_if,
  output logic        stall_dm
);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  logic                r_is_write;
  logic [CNT_W-1:0]    r_cnt;
  logic [STARVE_W-1:0] r_starve;
  logic [15:0]         r_mem_addr;
  logic [15:0]         r_mem_data;
  logic                r_mem_we;
  logic [15:0]         r_if_rdata;
  logic [15:0]         r_dm_rdata;
  logic                w_grant_if;
  logic                w_grant_dm;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .i_if_req  (if_req),
    .i_dm_req  (dm_req),
    .i_starve  (r_starve),
    .o_grant_if(w_grant_if),
    .o_grant_dm(w_grant_dm)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if_ready    = 1'b0;
    dm_ready    = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_grant_if || w_grant_dm) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (r_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if_ready    = (r_owner == OWN_IF);
        dm_ready    = (r_owner == OWN_DM);
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
    stall_if = if_req && !if_ready;
    stall_dm = dm_req && !dm_ready;
  end

  // Requests are only sampled at grant; a dropped req cannot cancel a transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner    <= OWN_IF;
      r_is_write <= 1'b0;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_dm) begin
            r_owner    <= OWN_DM;
            r_mem_addr <= dm_addr;
            r_mem_data <= dm_wdata;
            r_mem_we   <= dm_we;
            r_is_write <= dm_we;
            r_cnt      <= CNT_W'(WAIT_STATES);
            if (if_req && (r_starve < STARVE_W'(STARVE_MAX)))
              r_starve <= r_starve + 1'b1;
          end else if (w_grant_if) begin
            r_owner    <= OWN_IF;
            r_mem_addr <= if_addr;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
            r_is_write <= 1'b0;
            r_cnt      <= CNT_W'(WAIT_STATES);
            r_starve   <= '0;
          end
        end
        ST_ACCESS: begin
          r_mem_we <= 1'b0;
          if (r_cnt == '0) begin
            if (!r_is_write) begin
              if (r_owner == OWN_DM) r_dm_rdata <= mem_q;
              else                   r_if_rdata <= mem_q;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_mem_we <= 1'b0;
      endcase
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_we   = r_mem_we;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: table of single transfers plus
// hand-written multi-cycle sequences (arbitration, starvation, reset, wait states).
module tb_mem_port_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_ready, dm_ready, mem_we, stall_if, stall_dm;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_data, mem_q;

  logic        if_req2;
  logic [15:0] if_addr2;
  logic        dm_req2, dm_we2;
  logic [15:0] dm_addr2, dm_wdata2;
  logic        if_ready2, dm_ready2, mem_we2, stall_if2, stall_dm2;
  logic [15:0] if_rdata2, dm_rdata2, mem_addr2, mem_data2, mem_q2;

  mem_port_sequencer #(
    .WAIT_STATES(1),
    .STARVE_MAX (3)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  mem_port_sequencer #(
    .WAIT_STATES(2),
    .STARVE_MAX (3)
  ) dut2 (
    .clk(clk), .reset(reset),
    .if_req(if_req2), .if_addr(if_addr2), .if_ready(if_ready2), .if_rdata(if_rdata2),
    .dm_req(dm_req2), .dm_we(dm_we2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2),
    .dm_ready(dm_ready2), .dm_rdata(dm_rdata2),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_we(mem_we2), .mem_q(mem_q2),
    .stall_if(stall_if2), .stall_dm(stall_dm2)
  );

  // Synchronous memory: registered read, shared by both instances (only dut writes).
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_q  <= mem[mem_addr];
  end
  always @(posedge clk) mem_q2 <= mem[mem_addr2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    bit          is_if;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_if;
    logic [15:0] exp_dm;
  } vec_t;

  vec_t vecs [10];

  task automatic run_xfer(input vec_t v);
    int lat;
    int strobes;
    lat = -1;
    strobes = 0;
    @(posedge clk); #1;
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end
    for (int c = 0; c < 16 && lat < 0; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (mem_we) begin
        strobes++;
        chk("strobe_addr", 32'(mem_addr), 32'(v.addr));
        chk("strobe_data", 32'(mem_data), 32'(v.wdata));
      end
      chk("other_ready", 32'(v.is_if ? dm_ready : if_ready), 32'(0));
      if (v.is_if ? if_ready : dm_ready) begin
        lat = c;
        chk("stall_at_ready", 32'(v.is_if ? stall_if : stall_dm), 32'(0));
      end else begin
        chk("stall_wait", 32'(v.is_if ? stall_if : stall_dm), 32'(1));
      end
    end
    chk("latency", 32'(lat), 32'(3));
    chk("if_rdata", 32'(if_rdata), 32'(v.exp_if));
    chk("dm_rdata", 32'(dm_rdata), 32'(v.exp_dm));
    chk("strobes", 32'(strobes), 32'(v.we));
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  int  d_at, i_at, n, lat;
  bit  got [8];
  bit  exp_order [8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 16'h0040, 16'h0001, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0001, 16'h1234};
    vecs[6] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0001, 16'h0001};
    vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0001, 16'h0001};
    vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h0001};
    vecs[9] = '{1'b0, 1'b1, 16'hFFFE, 16'h7E57, 16'hA5A5, 16'h0001};
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    if_req = 1'b1; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_req2 = 1'b0; if_addr2 = '0;
    dm_req2 = 1'b0; dm_we2 = 1'b0; dm_addr2 = '0; dm_wdata2 = '0;
    #2 reset = 1'b0;

    // Reset state; stall flags follow the raw requests.
    #10;
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_if_ready", 32'(if_ready), 32'(0));
    chk("rst_dm_rdata", 32'(dm_rdata), 32'(0));
    chk("rst_stall_if", 32'(stall_if), 32'(1));
    chk("rst_stall_dm", 32'(stall_dm), 32'(0));
    if_req = 1'b0;
    #1 chk("rst_stall_if_drop", 32'(stall_if), 32'(0));
    @(negedge clk); #2 reset = 1'b1;

    for (int i = 0; i < 10; i++) run_xfer(vecs[i]);

    // Simultaneous requests: DM first, IF in the following IDLE.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010;
    d_at = -1; i_at = -1;
    for (int c = 0; c < 20 && i_at < 0; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (d_at >= 0) dm_req = 1'b0;
      end
      @(negedge clk);
      if (dm_ready && d_at < 0) d_at = c;
      if (if_ready) i_at = c;
      if (c == 3) chk("t4_stall_if", 32'(stall_if), 32'(1));
    end
    chk("t4_dm_ready_cycle", 32'(d_at), 32'(3));
    chk("t4_if_ready_cycle", 32'(i_at), 32'(7));
    chk("t4_if_rdata", 32'(if_rdata), 32'(16'h0001));
    chk("t4_dm_rdata", 32'(dm_rdata), 32'(16'h1234));
    @(posedge clk); #1 if_req = 1'b0;

    // Both held: three DM grants, then IF forced, then the pattern repeats.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010;
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      chk("t5_ready_excl", 32'(dm_ready & if_ready), 32'(0));
      if (dm_ready) begin
        got[n] = 1'b1; n++;
      end else if (if_ready) begin
        got[n] = 1'b0; n++;
      end
    end
    chk("t5_pulse_count", 32'(n), 32'(8));
    for (int i = 0; i < 8; i++) chk($sformatf("t5_order%0d", i), 32'(got[i]), 32'(exp_order[i]));
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during the write-strobe cycle of a store.
    chk("t1_dm_rdata_pre", 32'(dm_rdata), 32'(16'h1234));
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    chk("t1_we_pre", 32'(mem_we), 32'(1));
    #1 reset = 1'b0;
    #1;
    chk("t1_mem_we", 32'(mem_we), 32'(0));
    chk("t1_mem_addr", 32'(mem_addr), 32'(0));
    chk("t1_mem_data", 32'(mem_data), 32'(0));
    chk("t1_dm_rdata", 32'(dm_rdata), 32'(0));
    chk("t1_if_rdata", 32'(if_rdata), 32'(0));
    chk("t1_dm_ready", 32'(dm_ready), 32'(0));
    chk("t1_stall_dm", 32'(stall_dm), 32'(1));
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk); #2 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t1_no_ready", 32'(dm_ready), 32'(0));
      chk("t1_no_we", 32'(mem_we), 32'(0));
    end

    // Two wait states, fetch at the top of the address space.
    @(posedge clk); #1;
    if_req2 = 1'b1; if_addr2 = 16'hFFFE;
    lat = -1;
    for (int c = 0; c < 16 && lat < 0; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      chk("t6_mem_we", 32'(mem_we2), 32'(0));
      if (c >= 1 && c <= 3) chk("t6_mem_addr", 32'(mem_addr2), 32'(16'hFFFE));
      if (if_ready2) lat = c;
      else chk("t6_stall_if", 32'(stall_if2), 32'(1));
    end
    chk("t6_latency", 32'(lat), 32'(4));
    chk("t6_if_rdata", 32'(if_rdata2), 32'(16'h7E57));
    @(posedge clk); #1 if_req2 = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
